// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive framing path.
package uart_rx_pkg;

    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        LOAD      = 3'd4
    } rx_state_e;

endpackage

// File: rtl/flex_stp_sr.sv
// Generic serial-to-parallel shift register; SHIFT_MSB selects the shift direction.
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    // SHIFT_MSB=0 enters new bits at the MSB so the oldest bit ends up in bit 0
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
            end else begin
                parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
            end
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// Bit-period timer and data-bit counter; ticks mark the mid-bit sample point.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    input  logic half_period,
    input  logic count_bits,
    output logic sample_tick_c,
    output logic bits_done_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_cnt;

    // Half period only while confirming the start bit, to land on mid-bit
    assign sample_tick_c = (cnt == (half_period ? HALF_LAST : FULL_LAST));
    assign bits_done_c   = count_bits && sample_tick_c && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            if (restart || sample_tick_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (restart || bits_done_c) begin
                bit_cnt <= '0;
            end else if (count_bits && sample_tick_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framing: start detection, mid-bit sampling, stop check and
// a buffered output word with ready/overrun/framing status.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    logic                 sync_a;
    logic                 sync;
    logic                 hist;
    rx_state_e            state;
    logic                 stop_bit;
    logic [DATA_BITS-1:0] shifter;
    logic                 sample_tick;
    logic                 bits_done;
    logic                 start_edge;
    logic                 timer_restart;

    assign start_edge    = hist && !sync;
    assign timer_restart = ((state == IDLE) && start_edge) ||
                           ((state == START_CHK) && sample_tick && !sync);

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_a <= 1'b1;
            sync   <= 1'b1;
            hist   <= 1'b1;
        end else begin
            sync_a <= serial_in;
            sync   <= sync_a;
            hist   <= sync;
        end
    end

    rx_bit_timer #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .restart      (timer_restart),
        .half_period  (state == START_CHK),
        .count_bits   (state == DATA),
        .sample_tick_c(sample_tick),
        .bits_done_c  (bits_done)
    );

    flex_stp_sr #(
        .NUM_BITS (DATA_BITS),
        .SHIFT_MSB(1'b0)
    ) u_shift (
        .clk         (clk),
        .n_rst       (n_rst),
        .shift_enable(sample_tick && (state == DATA)),
        .serial_in   (sync),
        .parallel_out(shifter)
    );

    // Frame FSM with registered status; a read in the LOAD cycle loses to the load
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            stop_bit      <= 1'b1;
            rx_data       <= '1;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state         <= START_CHK;
                        framing_error <= 1'b0;
                    end
                end
                START_CHK: begin
                    if (sample_tick) begin
                        state <= sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bits_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        stop_bit <= sync;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                    if (stop_bit) begin
                        rx_data    <= shifter;
                        data_ready <= 1'b1;
                        if (data_ready && !data_read) begin
                            overrun_error <= 1'b1;
                        end
                    end else begin
                        framing_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
